// File: rtl/mul_div_unit_pkg.sv
// Shared operation codes for the EX-stage multiply/divide unit, plus small
// decode helpers so the unit and anything that talks to it agree on encodings.
package mul_div_unit_pkg;

  // Operation codes as defined by the shared EXE_*_OP defines of the core.
  localparam logic [7:0] EXE_MTHI_OP  = 8'b00010001;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b00010011;
  localparam logic [7:0] EXE_MULT_OP  = 8'b00011000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b00011001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b00011010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b00011011;

  // True for any operation this unit serves; everything else is ignored.
  function automatic logic isMdOp(input logic [7:0] op);
    return (op == EXE_MTHI_OP) || (op == EXE_MTLO_OP) ||
           (op == EXE_MULT_OP) || (op == EXE_MULTU_OP) ||
           (op == EXE_DIV_OP)  || (op == EXE_DIVU_OP);
  endfunction

  // True for the two divide flavours, which go through the iterative datapath.
  function automatic logic isDivOp(input logic [7:0] op);
    return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
  endfunction

endpackage

// File: rtl/mul_div_unit_div_iter.sv
// Restoring unsigned divider, one quotient bit per step. The parent supplies
// magnitudes and owns sign correction, divide-by-zero handling and sequencing.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] quoQ;
  logic [WIDTH-1:0] remQ;
  logic [WIDTH-1:0] dvsQ;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             fits;

  // Shift the next dividend bit into the partial remainder and trial-subtract.
  // When the trial fits, the difference is below the divisor and so fits WIDTH bits.
  always_comb begin
    shifted = {remQ, quoQ[WIDTH-1]};
    fits    = (shifted >= {1'b0, dvsQ});
    diff    = shifted[WIDTH-1:0] - dvsQ;
  end

  // Load seeds a fresh division; each step retires one quotient bit MSB-first,
  // reusing the quotient register as the dividend shift register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      quoQ <= '0;
      remQ <= '0;
      dvsQ <= '0;
    end else if (load) begin
      quoQ <= dividend;
      remQ <= '0;
      dvsQ <= divisor;
    end else if (step) begin
      if (fits) begin
        remQ <= diff;
        quoQ <= {quoQ[WIDTH-2:0], 1'b1};
      end else begin
        remQ <= shifted[WIDTH-1:0];
        quoQ <= {quoQ[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign quotient  = quoQ;
  assign remainder = remQ;

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Serves MULT/MULTU/DIV/DIVU/MTHI/MTLO; the pipeline holds while busy is high.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [7:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_by_zero
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_FIX  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    MUL  = ST_MUL,
    DIV  = ST_DIV,
    FIX  = ST_FIX
  } state_e;

  localparam int CNT_W = $clog2((WIDTH > MUL_LAT) ? WIDTH : MUL_LAT) + 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'((MUL_LAT > 1) ? (MUL_LAT - 2) : 0);

  state_e           stateQ;
  logic [CNT_W-1:0] cntQ;
  logic [WIDTH-1:0] aQ, bQ, hiQ, loQ;
  logic             signedQ, doneQ, dbzQ;

  logic             accept, opSigned, divLoad, divStep, negQuo, negRem;
  logic [WIDTH-1:0] absA, absB, quoMag, remMag, fixQuo, fixRem;

  // Full-width product; sign-extending both operands makes the low 2*WIDTH
  // bits the two's-complement product for MULT and the plain product for MULTU.
  function automatic logic [2*WIDTH-1:0] mulProduct(input logic sgn,
                                                    input logic [WIDTH-1:0] x,
                                                    input logic [WIDTH-1:0] y);
    logic [2*WIDTH-1:0] xe, ye;
    xe = {{WIDTH{sgn & x[WIDTH-1]}}, x};
    ye = {{WIDTH{sgn & y[WIDTH-1]}}, y};
    return xe * ye;
  endfunction

  // Accept decode, divider feed (magnitudes at accept) and the final sign fixup.
  always_comb begin
    accept   = start && !cancel && (stateQ == IDLE) && isMdOp(op);
    opSigned = (op == EXE_MULT_OP) || (op == EXE_DIV_OP);
    absA     = (opSigned && a[WIDTH-1]) ? -a : a;
    absB     = (opSigned && b[WIDTH-1]) ? -b : b;
    divLoad  = accept && isDivOp(op);
    divStep  = (stateQ == DIV) && !cancel;
    negQuo   = signedQ && (aQ[WIDTH-1] ^ bQ[WIDTH-1]);
    negRem   = signedQ && aQ[WIDTH-1];
    fixQuo   = negQuo ? -quoMag : quoMag;
    fixRem   = negRem ? -remMag : remMag;
  end

  div_iter #(.WIDTH(WIDTH)) u_div_iter (
    .clk       (clk),
    .resetn    (resetn),
    .load      (divLoad),
    .step      (divStep),
    .dividend  (absA),
    .divisor   (absB),
    .quotient  (quoMag),
    .remainder (remMag)
  );

  // Sequencer: accepts requests in IDLE, counts out the multiply and divide
  // latencies, and commits HI/LO together with a one-cycle done pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stateQ  <= IDLE;
      cntQ    <= '0;
      aQ      <= '0;
      bQ      <= '0;
      hiQ     <= '0;
      loQ     <= '0;
      signedQ <= 1'b0;
      doneQ   <= 1'b0;
      dbzQ    <= 1'b0;
    end else begin
      doneQ <= 1'b0;
      unique case (stateQ)
        IDLE: begin
          if (accept) begin
            dbzQ    <= 1'b0;
            aQ      <= a;
            bQ      <= b;
            signedQ <= opSigned;
            cntQ    <= '0;
            unique case (op)
              EXE_MTHI_OP: begin
                hiQ   <= a;
                doneQ <= 1'b1;
              end
              EXE_MTLO_OP: begin
                loQ   <= a;
                doneQ <= 1'b1;
              end
              EXE_MULT_OP, EXE_MULTU_OP: begin
                if (MUL_LAT == 1) begin
                  {hiQ, loQ} <= mulProduct(opSigned, a, b);
                  doneQ      <= 1'b1;
                end else begin
                  stateQ <= MUL;
                end
              end
              default: stateQ <= DIV;
            endcase
          end
        end
        MUL: begin
          if (cancel) begin
            stateQ <= IDLE;
          end else if (cntQ == MUL_LAST) begin
            {hiQ, loQ} <= mulProduct(signedQ, aQ, bQ);
            doneQ      <= 1'b1;
            stateQ     <= IDLE;
          end else begin
            cntQ <= cntQ + 1'b1;
          end
        end
        DIV: begin
          if (cancel) begin
            stateQ <= IDLE;
          end else if (cntQ == DIV_LAST) begin
            stateQ <= FIX;
          end else begin
            cntQ <= cntQ + 1'b1;
          end
        end
        FIX: begin
          stateQ <= IDLE;
          if (!cancel) begin
            doneQ <= 1'b1;
            if (bQ == '0) begin
              loQ  <= '1;
              hiQ  <= aQ;
              dbzQ <= 1'b1;
            end else begin
              loQ <= fixQuo;
              hiQ <= fixRem;
            end
          end
        end
        default: stateQ <= IDLE;
      endcase
    end
  end

  assign busy        = (stateQ != IDLE);
  assign done        = doneQ;
  assign hi_o        = hiQ;
  assign lo_o        = loQ;
  assign div_by_zero = dbzQ;

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers, parametrised in operand width.
- Sits in the EX stage beside the ALU and serves the MULT, MULTU, DIV, DIVU, MTHI and MTLO operations; MFHI/MFLO read hi_o/lo_o directly.
- The pipeline stalls on busy and squashes an in-flight operation through cancel on an exception or flush.

Parameters:
- WIDTH, 32, operand width in bits; HI and LO are WIDTH bits each.
- MUL_LAT, 2, cycles from accept to done for MULT/MULTU; minimum 1.

Ports:
- clk  in  1  single clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  request valid for one cycle; accepted only when the unit is idle.
- op  in  8  operation code using the shared EXE_*_OP defines.
- a  in  WIDTH  rs operand (dividend, multiplicand, or MTHI/MTLO source).
- b  in  WIDTH  rt operand (divisor, multiplier).
- cancel  in  1  aborts any in-flight operation.
- busy  out  1  operation in flight; the pipeline must hold.
- done  out  1  one-cycle pulse; HI/LO are updated in the same cycle.
- hi_o  out  WIDTH  HI register.
- lo_o  out  WIDTH  LO register.
- div_by_zero  out  1  sticky until the next accepted op; set when a DIV/DIVU had b==0.

Behaviour:
- Reset (asynchronous, resetn=0): state=IDLE, busy=0, done=0, hi_o=0, lo_o=0, div_by_zero=0, internal counters and accumulators 0.
- Reset asserted mid-operation aborts immediately; no done is produced.
- Accept rule: cycle 0 is a cycle with start=1, state IDLE, cancel=0 and a recognised op. Operands are latched at the end of cycle 0.
- Ignored requests:
  - start while busy: ignored, no queueing.
  - Unrecognised op: ignored, no done.
  - Accept clears div_by_zero.
- State machine: IDLE, MUL, DIV, FIX.
  - IDLE -> MUL (MULT/MULTU), DIV (DIV/DIVU), or stays IDLE for MTHI/MTLO.
  - MUL -> IDLE after MUL_LAT-1 cycles.
  - DIV -> FIX after WIDTH iterations.
  - FIX -> IDLE after 1 cycle.
- Latency N, with done=1 in cycle N and HI/LO carrying the new value from cycle N onward:
  - MTHI/MTLO: N=1; hi_o<=a or lo_o<=a respectively; the other register is unchanged.
  - MULT/MULTU: N=MUL_LAT; the 2*WIDTH-bit product splits as {hi,lo}.
  - DIV/DIVU: N=WIDTH+2, i.e. WIDTH restoring iterations plus 1 sign-fixup cycle; lo=quotient, hi=remainder.
- busy=1 in cycles 1..N-1 and 0 in cycle N, so a new start can be accepted in cycle N (back-to-back).
- Signed arithmetic:
  - MULT: two's-complement product of sign-extended operands.
  - DIV: divide magnitudes, then in FIX negate the quotient if sign(a)!=sign(b) and negate the remainder if a<0.
  - The remainder takes the sign of the dividend (truncating division).
- Signed overflow: a = most-negative, b = -1 gives lo = most-negative, hi = 0. No flag, no exception.
- Divide by zero (b==0, either signedness):
  - Full latency is still taken.
  - lo = all ones, hi = a.
  - div_by_zero=1 from cycle N.
- cancel:
  - When busy, return to IDLE on the next edge; HI/LO unchanged; no done.
  - In the same cycle as start, cancel wins and start is dropped.
  - In cycle N (done cycle) it has no effect; the write stands.
- done is a registered pulse and is never high for two consecutive cycles for one operation.

Decomposition:
- Op codes (EXE_MULT_OP, EXE_MULTU_OP, EXE_DIV_OP, EXE_DIVU_OP, EXE_MTHI_OP, EXE_MTLO_OP) come from the shared defines.vh. No new local encodings.
- State encodings are localparams in this module.
- One natural sub-module: div_iter, the restoring-division datapath.
  - Inputs: magnitudes, a load strobe and a step enable.
  - Outputs: quotient and remainder magnitudes.
  - The parent owns sign handling and the FSM.
- The multiplier is an inline product followed by a MUL_LAT-deep register pipe.

Test Plan:
- Reset then MTHI a=0x12345678, next MTLO a=0x9ABCDEF0 -> done in cycle 1 each; hi_o=0x12345678, lo_o=0x9ABCDEF0.
- MULT a=0xFFFFFFFE (-2), b=0x00000003 -> done in cycle 2 (MUL_LAT=2); hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=-7 (0xFFFFFFF9), b=2 -> busy cycles 1..33, done cycle 34; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 -> lo=14, hi=2.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU a=5, b=0 -> lo=0xFFFFFFFF, hi=5, div_by_zero=1; the next MTLO clears it.
- Start DIVU, assert cancel in cycle 10 -> busy=0 in cycle 11, no done, HI/LO unchanged. start+cancel together -> not accepted. start while busy -> ignored, and the first op's result is intact.
- Back-to-back: MULT accepted, new DIVU start in the MULT done cycle -> accepted; second done follows 34 cycles later. resetn pulsed low mid-DIV -> all outputs 0 immediately, no done.
